// File: rtl/vga_pixel_prefetch_if.sv
// rtl/vga_pixel_prefetch_if.sv - pixel prefetcher signal bundle (sync/consumer/RAM side vs prefetcher)
interface vga_pixel_prefetch_if;
    logic        frame_start;
    logic        pixel_req;
    logic [7:0]  pixel_data;
    logic        pixel_valid;
    logic        underflow;
    logic        fetch_active;
    logic [14:0] ram_address;
    logic [15:0] data_from_ram;

    modport master (
        output frame_start, pixel_req, data_from_ram,
        input  pixel_data, pixel_valid, underflow, fetch_active, ram_address
    );

    modport slave (
        input  frame_start, pixel_req, data_from_ram,
        output pixel_data, pixel_valid, underflow, fetch_active, ram_address
    );
endinterface

// File: rtl/vga_pixel_prefetch.sv
// rtl/vga_pixel_prefetch.sv - frame-buffer word prefetcher feeding RGB332 pixels, two per word
module vga_pixel_prefetch #(
    parameter logic [14:0] BASE_ADDR       = 15'd0,
    parameter int          WORDS_PER_FRAME = 30720,
    parameter int          FIFO_DEPTH      = 8
) (
    input logic                  clk,
    input logic                  reset,
    vga_pixel_prefetch_if.slave  bus
);
    localparam int          PTR_W = $clog2(FIFO_DEPTH);
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [15:0] WPF   = 16'(WORDS_PER_FRAME);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              byte_sel;
    logic              rd_pending;
    logic              underflow_r;
    logic              fetch_active_r;
    logic [14:0]       ram_address_r;
    logic [15:0]       words_issued;
    logic [15:0]       head;
    logic              pixel_valid;
    logic              push;
    logic              pop;
    logic              retire;
    logic              issue;

    assign head        = fifo_mem[rd_ptr];
    assign pixel_valid = (count != '0);
    // A restart discards both the in-flight capture and any pop in the same cycle.
    assign push        = rd_pending && !bus.frame_start;
    assign pop         = bus.pixel_req && pixel_valid && !bus.frame_start;
    assign retire      = pop && byte_sel;
    // The pending read reserves a slot, so the FIFO can never be pushed while full.
    assign issue       = (state == RUN)
                         && ((32'(count) + 32'(rd_pending)) < 32'(FIFO_DEPTH))
                         && (words_issued < WPF);

    assign bus.pixel_valid  = pixel_valid;
    assign bus.pixel_data   = pixel_valid ? (byte_sel ? head[7:0] : head[15:8]) : 8'h00;
    assign bus.underflow    = underflow_r;
    assign bus.fetch_active = fetch_active_r;
    assign bus.ram_address  = ram_address_r;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.data_from_ram;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            fetch_active_r <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            byte_sel       <= 1'b0;
            rd_pending     <= 1'b0;
            underflow_r    <= 1'b0;
            ram_address_r  <= BASE_ADDR;
            words_issued   <= '0;
        end else if (bus.frame_start) begin
            state          <= RUN;
            fetch_active_r <= 1'b1;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            byte_sel       <= 1'b0;
            rd_pending     <= 1'b0;
            underflow_r    <= 1'b0;
            ram_address_r  <= BASE_ADDR;
            words_issued   <= '0;
        end else begin
            rd_pending <= issue;
            if (issue) begin
                ram_address_r <= ram_address_r + 15'd1;
                words_issued  <= words_issued + 16'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                byte_sel <= !byte_sel;
                if (byte_sel) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
            if (push && !retire) begin
                count <= count + CNT_W'(1);
            end else if (!push && retire) begin
                count <= count - CNT_W'(1);
            end
            if (bus.pixel_req && !pixel_valid) begin
                underflow_r <= 1'b1;
            end
            case (state)
                RUN: begin
                    if (words_issued == WPF) begin
                        state          <= DONE;
                        fetch_active_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_pixel_prefetch.sv
// tb/tb_vga_pixel_prefetch.sv - directed scoreboard bench for vga_pixel_prefetch
module tb_vga_pixel_prefetch;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] mem [0:32767];
    logic [7:0]  sb [$];

    vga_pixel_prefetch_if if_def ();
    vga_pixel_prefetch_if if_4 ();
    vga_pixel_prefetch_if if_w ();

    vga_pixel_prefetch u_def (.clk(clk), .reset(reset), .bus(if_def));

    vga_pixel_prefetch #(.BASE_ADDR(15'd0), .WORDS_PER_FRAME(4), .FIFO_DEPTH(8))
        u_4 (.clk(clk), .reset(reset), .bus(if_4));

    vga_pixel_prefetch #(.BASE_ADDR(15'd32766), .WORDS_PER_FRAME(4), .FIFO_DEPTH(8))
        u_w (.clk(clk), .reset(reset), .bus(if_w));

    always #5 clk = ~clk;

    // Synchronous RAM: data for the sampled address appears one cycle later.
    always @(posedge clk) begin
        if_def.data_from_ram <= mem[if_def.ram_address];
        if_4.data_from_ram   <= mem[if_4.ram_address];
        if_w.data_from_ram   <= mem[if_w.ram_address];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        sb.push_back(w[15:8]);
        sb.push_back(w[7:0]);
    endtask

    task automatic chk_pix(input string tag, input logic [7:0] obs);
        logic [7:0] exp;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, obs);
        end else begin
            exp = sb.pop_front();
            chk(tag, {24'd0, obs}, {24'd0, exp});
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'(i) ^ 16'hC3A5;
        mem[0] = 16'h1234;
        mem[1] = 16'h5678;
        mem[2] = 16'h9ABC;
        mem[3] = 16'hDEF0;

        if_def.frame_start = 1'b0; if_def.pixel_req = 1'b0;
        if_4.frame_start   = 1'b0; if_4.pixel_req   = 1'b0;
        if_w.frame_start   = 1'b0; if_w.pixel_req   = 1'b0;

        repeat (3) tick();
        chk("rst_valid", 32'(if_def.pixel_valid), 32'd0);
        chk("rst_data", 32'(if_def.pixel_data), 32'd0);
        chk("rst_addr_w", 32'(if_w.ram_address), 32'd32766);
        reset = 1'b0;
        tick();

        // Reset asserted mid-stream, checked without any clock edge.
        if_def.frame_start = 1'b1; tick(); if_def.frame_start = 1'b0;
        if_def.pixel_req = 1'b1;  tick(); if_def.pixel_req = 1'b0;
        tick(); tick();
        chk("t1_pre_active", 32'(if_def.fetch_active), 32'd1);
        chk("t1_pre_underflow", 32'(if_def.underflow), 32'd1);
        chk("t1_pre_valid", 32'(if_def.pixel_valid), 32'd1);
        chk("t1_pre_addr", 32'(if_def.ram_address), 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("t1_addr", 32'(if_def.ram_address), 32'd0);
        chk("t1_valid", 32'(if_def.pixel_valid), 32'd0);
        chk("t1_data", 32'(if_def.pixel_data), 32'd0);
        chk("t1_underflow", 32'(if_def.underflow), 32'd0);
        chk("t1_active", 32'(if_def.fetch_active), 32'd0);
        #1 reset = 1'b0;
        tick();

        // Four-word frame drained continuously, then one extra request.
        if_4.frame_start = 1'b1;
        for (int i = 0; i < 4; i++) push_word(mem[i]);
        tick(); if_4.frame_start = 1'b0;
        chk("t2_active", 32'(if_4.fetch_active), 32'd1);
        chk("t2_valid_e0", 32'(if_4.pixel_valid), 32'd0);
        tick();
        chk("t2_valid_e1", 32'(if_4.pixel_valid), 32'd0);
        tick();
        chk("t2_valid_e2", 32'(if_4.pixel_valid), 32'd1);
        if_4.pixel_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t2_valid", 32'(if_4.pixel_valid), 32'd1);
            chk_pix("t2_pixel", if_4.pixel_data);
            tick();
        end
        chk("t2_underflow", 32'(if_4.underflow), 32'd0);
        chk("t4_valid", 32'(if_4.pixel_valid), 32'd0);
        chk("t4_data", 32'(if_4.pixel_data), 32'd0);
        tick();
        if_4.pixel_req = 1'b0;
        chk("t4_underflow", 32'(if_4.underflow), 32'd1);
        chk("t2_done", 32'(if_4.fetch_active), 32'd0);
        chk("t2_addr", 32'(if_4.ram_address), 32'd4);

        // Default build without consumer: prefetch stops at FIFO depth.
        if_def.frame_start = 1'b1; tick(); if_def.frame_start = 1'b0;
        repeat (20) tick();
        chk("t3_addr_full", 32'(if_def.ram_address), 32'd8);
        chk("t3_valid", 32'(if_def.pixel_valid), 32'd1);
        push_word(mem[0]);
        if_def.pixel_req = 1'b1;
        chk_pix("t3_pixel", if_def.pixel_data);
        tick();
        chk_pix("t3_pixel", if_def.pixel_data);
        tick();
        if_def.pixel_req = 1'b0;
        repeat (5) tick();
        chk("t3_addr_refill", 32'(if_def.ram_address), 32'd9);

        // Restart with 5 words buffered, a read in flight and a simultaneous pop.
        if_def.frame_start = 1'b1; tick(); if_def.frame_start = 1'b0;
        if_def.pixel_req = 1'b1;  tick(); if_def.pixel_req = 1'b0;
        chk("t5_underflow_set", 32'(if_def.underflow), 32'd1);
        repeat (5) tick();
        chk("t5_pre_addr", 32'(if_def.ram_address), 32'd6);
        chk("t5_pre_valid", 32'(if_def.pixel_valid), 32'd1);
        if_def.frame_start = 1'b1;
        if_def.pixel_req = 1'b1;
        push_word(mem[0]);
        tick();
        if_def.frame_start = 1'b0;
        if_def.pixel_req = 1'b0;
        chk("t5_valid_flush", 32'(if_def.pixel_valid), 32'd0);
        chk("t5_addr_base", 32'(if_def.ram_address), 32'd0);
        chk("t5_underflow_clr", 32'(if_def.underflow), 32'd0);
        tick();
        chk("t5_no_stale", 32'(if_def.pixel_valid), 32'd0);
        chk("t5_addr_next", 32'(if_def.ram_address), 32'd1);
        tick();
        chk("t5_valid", 32'(if_def.pixel_valid), 32'd1);
        if_def.pixel_req = 1'b1;
        chk_pix("t5_pixel", if_def.pixel_data);
        tick();
        chk_pix("t5_pixel", if_def.pixel_data);
        tick();
        if_def.pixel_req = 1'b0;

        // Address wrap at the top of the 15-bit space.
        if_w.frame_start = 1'b1; tick(); if_w.frame_start = 1'b0;
        chk("t6_addr0", 32'(if_w.ram_address), 32'd32766);
        tick(); chk("t6_addr1", 32'(if_w.ram_address), 32'd32767);
        tick(); chk("t6_addr2", 32'(if_w.ram_address), 32'd0);
        tick(); chk("t6_addr3", 32'(if_w.ram_address), 32'd1);
        tick(); chk("t6_addr4", 32'(if_w.ram_address), 32'd2);
        tick(); tick();
        chk("t6_addr_hold", 32'(if_w.ram_address), 32'd2);
        chk("t6_done", 32'(if_w.fetch_active), 32'd0);
        push_word(mem[32766]);
        push_word(mem[32767]);
        push_word(mem[0]);
        if_w.pixel_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk_pix("t6_pixel", if_w.pixel_data);
            tick();
        end
        if_w.pixel_req = 1'b0;
        chk("t6_sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
